exec_arith_unit: RTL and testbench

- Integer add/subtract/absolute-value execute slice of the in-order pipeline's execute stage.
- Combines add/sub, add/sub-with-carry and absolute value into one registered unit.
- Owns the architectural 4-bit flags register (C, Z, S, V).
- Operands arrive already resolved (register or sign/zero-extended immediate). The result and valid register for one cycle before writeback.

---
 rtl/exec_arith_pkg.sv | 32 +++
 rtl/exec_arith_adder.sv | 54 +++++
 rtl/exec_arith_unit.sv | 169 ++++++++++++++++
 tb/tb_exec_arith_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/exec_arith_pkg.sv
// -----------------------------------------------------------------------------
// exec_arith_pkg
// Shared definitions for the execute-stage add/sub/abs slice:
//   W_OPR    operand/result width
//   W_FLAGS  flags register width (fixed at 4)
//   op_e     operation encodings carried on op_i
//   F_*      bit positions inside the flags register {V,S,Z,C}
// Optional feature macro used by the top level: EXEC_ABS_SAT_EN
// -----------------------------------------------------------------------------
package exec_arith_pkg;

  localparam int W_OPR   = 32;
  localparam int W_FLAGS = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_ADC = 2'b01,
    OP_ABS = 2'b10,
    OP_NOP = 2'b11
  } op_e;

  localparam int F_C = 0;
  localparam int F_Z = 1;
  localparam int F_S = 2;
  localparam int F_V = 3;

  // True when every bit of the operand is clear.
  function automatic logic is_zero(input logic [W_OPR-1:0] x);
    return (x == {W_OPR{1'b0}});
  endfunction

endpackage

// File: rtl/exec_arith_adder.sv
// -----------------------------------------------------------------------------
// exec_arith_adder
// Purely combinational add/subtract core shared by ADD, ADC and ABS (0 - B).
// Ports:
//   a, b   in  W_OPR   operands
//   cin    in  1       carry-in for add form, borrow-in for subtract form
//   sub    in  1       0 = a + b + cin, 1 = a - b - cin
//   sum    out W_OPR   wrapped result
//   flags  out W_FLAGS {V,S,Z,C}; C is carry-out (add) or borrow-out (sub)
// -----------------------------------------------------------------------------
module exec_arith_adder
  import exec_arith_pkg::*;
(
  input  logic [W_OPR-1:0]   a,
  input  logic [W_OPR-1:0]   b,
  input  logic               cin,
  input  logic               sub,
  output logic [W_OPR-1:0]   sum,
  output logic [W_FLAGS-1:0] flags
);

  logic [W_OPR-1:0] b_eff_s;
  logic             cin_eff_s;
  logic [W_OPR:0]   wide_s;
  logic [W_OPR-1:0] sum_s;

  // Subtraction is a + ~b + ~borrow_in: the borrow-in becomes an inverted
  // carry-in, and the carry-out of that sum is the inverse of the borrow-out.
  always_comb begin
    if (sub) begin
      b_eff_s   = ~b;
      cin_eff_s = ~cin;
    end else begin
      b_eff_s   = b;
      cin_eff_s = cin;
    end
    wide_s = {1'b0, a} + {1'b0, b_eff_s} + {{W_OPR{1'b0}}, cin_eff_s};
    sum_s  = wide_s[W_OPR-1:0];
  end

  // Flag derivation. Overflow compares signs against the effective (possibly
  // inverted) B, which yields both the add-form and subtract-form rules.
  always_comb begin
    flags      = {W_FLAGS{1'b0}};
    flags[F_C] = sub ? ~wide_s[W_OPR] : wide_s[W_OPR];
    flags[F_Z] = is_zero(sum_s);
    flags[F_S] = sum_s[W_OPR-1];
    flags[F_V] = (a[W_OPR-1] == b_eff_s[W_OPR-1]) &&
                 (sum_s[W_OPR-1] != a[W_OPR-1]);
  end

  assign sum = sum_s;

endmodule

// File: rtl/exec_arith_unit.sv
// -----------------------------------------------------------------------------
// exec_arith_unit
// Registered integer ADD / ADC / ABS execute slice owning the {V,S,Z,C}
// architectural flags register.
// Ports:
//   clk       in  1        rising-edge clock
//   reset     in  1        asynchronous active-low reset
//   v_i       in  1        instruction valid
//   stall_i   in  1        holds every register when 1
//   op_i      in  2        00 ADD, 01 ADC, 10 ABS, 11 NOP
//   sub_i     in  1        subtract form for ADD/ADC
//   opr0_i    in  W_OPR    operand A
//   opr1_i    in  W_OPR    operand B
//   v_o       out 1        registered valid
//   result_o  out W_OPR    registered result
//   flags_o   out W_FLAGS  flags register
//   stall_o   out 1        stall_i passed straight through
// Optional feature: define EXEC_ABS_SAT_EN to saturate ABS(most-negative)
// to the most-positive value instead of wrapping.
// -----------------------------------------------------------------------------
module exec_arith_unit
  import exec_arith_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               v_i,
  input  logic               stall_i,
  input  logic [1:0]         op_i,
  input  logic               sub_i,
  input  logic [W_OPR-1:0]   opr0_i,
  input  logic [W_OPR-1:0]   opr1_i,
  output logic               v_o,
  output logic [W_OPR-1:0]   result_o,
  output logic [W_FLAGS-1:0] flags_o,
  output logic               stall_o
);

  logic [W_OPR-1:0]   add_a_s;
  logic [W_OPR-1:0]   add_b_s;
  logic               add_cin_s;
  logic               add_sub_s;
  logic [W_OPR-1:0]   add_sum_s;
  logic [W_FLAGS-1:0] add_flags_s;

  logic [W_OPR-1:0]   abs_raw_s;
  logic [W_OPR-1:0]   res_s;
  logic [W_FLAGS-1:0] flags_next_s;
  logic               flags_load_s;

  logic               v_r;
  logic [W_OPR-1:0]   result_r;
  logic [W_FLAGS-1:0] flags_r;

  // Steer operands into the shared adder; ABS is computed as 0 - B.
  always_comb begin
    add_a_s   = {W_OPR{1'b0}};
    add_b_s   = {W_OPR{1'b0}};
    add_cin_s = 1'b0;
    add_sub_s = 1'b0;
    case (op_i)
      OP_ADD: begin
        add_a_s   = opr0_i;
        add_b_s   = opr1_i;
        add_cin_s = 1'b0;
        add_sub_s = sub_i;
      end
      OP_ADC: begin
        // Carry/borrow-in comes from the registered flags, so an ADD in the
        // previous cycle chains into this ADC.
        add_a_s   = opr0_i;
        add_b_s   = opr1_i;
        add_cin_s = flags_r[F_C];
        add_sub_s = sub_i;
      end
      OP_ABS: begin
        add_a_s   = {W_OPR{1'b0}};
        add_b_s   = opr1_i;
        add_cin_s = 1'b0;
        add_sub_s = 1'b1;
      end
      default: begin
        add_a_s   = {W_OPR{1'b0}};
        add_b_s   = {W_OPR{1'b0}};
        add_cin_s = 1'b0;
        add_sub_s = 1'b0;
      end
    endcase
  end

  exec_arith_adder u_adder (
    .a     (add_a_s),
    .b     (add_b_s),
    .cin   (add_cin_s),
    .sub   (add_sub_s),
    .sum   (add_sum_s),
    .flags (add_flags_s)
  );

  // Absolute value: negated B only when B is negative, else B itself.
  always_comb begin
    if (opr1_i[W_OPR-1]) begin
      abs_raw_s = add_sum_s;
    end else begin
      abs_raw_s = opr1_i;
    end
  end

  // Result and next-flags selection per operation.
  always_comb begin
    res_s        = {W_OPR{1'b0}};
    flags_next_s = flags_r;
    case (op_i)
      OP_ADD, OP_ADC: begin
        res_s        = add_sum_s;
        flags_next_s = add_flags_s;
      end
      OP_ABS: begin
        // 0 - B overflows exactly when B is the most-negative value.
`ifdef EXEC_ABS_SAT_EN
        res_s = add_flags_s[F_V] ? {1'b0, {(W_OPR-1){1'b1}}} : abs_raw_s;
`else
        res_s = abs_raw_s;
`endif
        flags_next_s      = {W_FLAGS{1'b0}};
        flags_next_s[F_C] = 1'b0;
        flags_next_s[F_Z] = is_zero(res_s);
        flags_next_s[F_S] = res_s[W_OPR-1];
        flags_next_s[F_V] = add_flags_s[F_V];
      end
      default: begin
        res_s        = {W_OPR{1'b0}};
        flags_next_s = flags_r;
      end
    endcase
  end

  assign flags_load_s = !stall_i && v_i && (op_i != OP_NOP);

  // Valid and result pipeline register; advances whenever not stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_r      <= 1'b0;
      result_r <= {W_OPR{1'b0}};
    end else if (!stall_i) begin
      v_r      <= v_i;
      result_r <= res_s;
    end else begin
      v_r      <= v_r;
      result_r <= result_r;
    end
  end

  // Architectural flags register; updates only for valid, non-NOP, unstalled ops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_r <= {W_FLAGS{1'b0}};
    end else if (flags_load_s) begin
      flags_r <= flags_next_s;
    end else begin
      flags_r <= flags_r;
    end
  end

  assign v_o      = v_r;
  assign result_o = result_r;
  assign flags_o  = flags_r;
  assign stall_o  = stall_i;

endmodule

// File: tb/tb_exec_arith_unit.sv
// -----------------------------------------------------------------------------
// tb_exec_arith_unit
// Directed vectors with literal expectations, plus a behavioural reference
// (signed/unsigned 64-bit arithmetic) compared against the DUT every cycle.
// -----------------------------------------------------------------------------
module tb_exec_arith_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        v_i = 1'b0;
  logic        stall_i = 1'b0;
  logic [1:0]  op_i = 2'b11;
  logic        sub_i = 1'b0;
  logic [31:0] opr0_i = 32'h0;
  logic [31:0] opr1_i = 32'h0;
  logic        v_o;
  logic [31:0] result_o;
  logic [3:0]  flags_o;
  logic        stall_o;

  int n_vec = 0;
  int n_err = 0;

  exec_arith_unit dut (
    .clk      (clk),
    .reset    (reset),
    .v_i      (v_i),
    .stall_i  (stall_i),
    .op_i     (op_i),
    .sub_i    (sub_i),
    .opr0_i   (opr0_i),
    .opr1_i   (opr1_i),
    .v_o      (v_o),
    .result_o (result_o),
    .flags_o  (flags_o),
    .stall_o  (stall_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: returns {V,S,Z,C, result} from the arithmetic definitions.
  function automatic logic [35:0] ref_op(input logic [1:0] op, input logic sub,
                                         input logic [31:0] a, input logic [31:0] b,
                                         input logic cf);
    longint unsigned ua, ub, uc, us;
    longint sa, sb, sr;
    logic [31:0] r;
    logic c, v;
    ua = {32'h0, a};
    ub = {32'h0, b};
    uc = (op == 2'b01) ? {63'h0, cf} : 64'h0;
    sa = $signed(a);
    sb = $signed(b);
    r = 32'h0; c = 1'b0; v = 1'b0;
    if (op == 2'b00 || op == 2'b01) begin
      if (!sub) begin
        us = ua + ub + uc;
        r  = us[31:0];
        c  = (us > 64'h0000_0000_FFFF_FFFF);
        sr = sa + sb + longint'(uc);
      end else begin
        us = ua - ub - uc;
        r  = us[31:0];
        c  = (ua < ub + uc);
        sr = sa - sb - longint'(uc);
      end
      v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    end else if (op == 2'b10) begin
      if (b == 32'h8000_0000) begin
        v = 1'b1;
`ifdef EXEC_ABS_SAT_EN
        r = 32'h7FFF_FFFF;
`else
        r = 32'h8000_0000;
`endif
      end else begin
        sr = (sb < 0) ? -sb : sb;
        r  = sr[31:0];
      end
      c = 1'b0;
    end
    return {v, r[31], (r == 32'h0), c, r};
  endfunction

  // Reference state, updated with the same visible timing as the unit.
  logic        m_v = 1'b0;
  logic [31:0] m_res = 32'h0;
  logic [3:0]  m_flags = 4'h0;
  logic [35:0] m_tmp;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_v     <= 1'b0;
      m_res   <= 32'h0;
      m_flags <= 4'h0;
    end else if (!stall_i) begin
      m_tmp = ref_op(op_i, sub_i, opr0_i, opr1_i, m_flags[0]);
      m_v   <= v_i;
      m_res <= m_tmp[31:0];
      if (v_i && op_i != 2'b11) m_flags <= m_tmp[35:32];
    end
  end

  // Continuous comparison on the falling edge, away from the update edge.
  always @(negedge clk) begin
    chk("model v_o", {31'h0, v_o}, {31'h0, m_v});
    chk("model result_o", result_o, m_res);
    chk("model flags_o", {28'h0, flags_o}, {28'h0, m_flags});
    chk("stall_o", {31'h0, stall_o}, {31'h0, stall_i});
  end

  task automatic drive(input logic v, input logic st, input logic [1:0] op,
                       input logic sb, input logic [31:0] a, input logic [31:0] b);
    v_i = v; stall_i = st; op_i = op; sub_i = sb; opr0_i = a; opr1_i = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [31:0] r,
                            input logic [3:0] f);
    chk({name, " v_o"}, {31'h0, v_o}, {31'h0, v});
    chk({name, " result_o"}, result_o, r);
    chk({name, " flags_o"}, {28'h0, flags_o}, {28'h0, f});
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    expect_out("reset", 1'b0, 32'h0, 4'b0000);
    tick();
    tick();
    reset = 1'b1;

    // Model anchors with hand-computed values.
    chk("ref add ovf", ref_op(2'b00, 1'b0, 32'h7FFF_FFFF, 32'h1, 1'b0), {4'b1100, 32'h8000_0000});
    chk("ref adc sub", ref_op(2'b01, 1'b1, 32'd10, 32'd3, 1'b1), {4'b0000, 32'd6});

    drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h7FFF_FFFF, 32'h1); tick();
    expect_out("add ovf", 1'b1, 32'h8000_0000, 4'b1100);
    drive(1'b1, 1'b0, 2'b00, 1'b1, 32'd3, 32'd5); tick();
    expect_out("sub borrow", 1'b1, 32'hFFFF_FFFE, 4'b0101);
    drive(1'b1, 1'b0, 2'b00, 1'b1, 32'd5, 32'd5); tick();
    expect_out("sub zero", 1'b1, 32'h0, 4'b0010);
    drive(1'b1, 1'b0, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'h1); tick();
    expect_out("add carry", 1'b1, 32'h0, 4'b0011);
    drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h0, 32'h0); tick();
    expect_out("adc chain", 1'b1, 32'h1, 4'b0000);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h1234_5678, 32'hFFFF_FFFB); tick();
    expect_out("abs neg", 1'b1, 32'd5, 4'b0000);
    drive(1'b1, 1'b0, 2'b10, 1'b1, 32'h0, 32'h8000_0000); tick();
`ifdef EXEC_ABS_SAT_EN
    expect_out("abs min", 1'b1, 32'h7FFF_FFFF, 4'b1000);
`else
    expect_out("abs min", 1'b1, 32'h8000_0000, 4'b1100);
`endif
    drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h0, 32'h1); tick();
    expect_out("sub wrap", 1'b1, 32'hFFFF_FFFF, 4'b0101);
    drive(1'b1, 1'b0, 2'b01, 1'b1, 32'd10, 32'd3); tick();
    expect_out("sbc borrow-in", 1'b1, 32'd6, 4'b0000);

    // Stall for three cycles with changing inputs: everything holds.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 2'(i), 1'b1, 32'(i + 7), 32'h8000_0000);
      tick();
      expect_out("stall hold", 1'b1, 32'd6, 4'b0000);
    end

    // Invalid ADD: result still advances, flags hold.
    drive(1'b0, 1'b0, 2'b00, 1'b1, 32'h0, 32'h0); tick();
    expect_out("invalid add", 1'b0, 32'h0, 4'b0000);

    drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h8000_0000, 32'h8000_0000); tick();
    expect_out("add min+min", 1'b1, 32'h0, 4'b1011);
    drive(1'b1, 1'b0, 2'b11, 1'b0, 32'd5, 32'd5); tick();
    expect_out("nop", 1'b1, 32'h0, 4'b1011);

    // Pseudo-random traffic checked by the reference model.
    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom, ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom);
      tick();
    end

    // Build a nonzero state, then drop reset between edges.
    drive(1'b1, 1'b0, 2'b00, 1'b1, 32'd1, 32'd2); tick();
    expect_out("pre-reset", 1'b1, 32'hFFFF_FFFF, 4'b0101);
    #2 reset = 1'b0;
    #1;
    expect_out("async reset", 1'b0, 32'h0, 4'b0000);
    tick();
    expect_out("held reset", 1'b0, 32'h0, 4'b0000);
    reset = 1'b1;
    drive(1'b0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
